// File: rtl/irq_arbiter_if.sv
// Signal bundle between the interrupt arbiter, its external interrupt lines and the CPU core.
// The master modport drives interrupt lines, mask writes and ack/eoi; the slave modport is the arbiter.
interface irq_arbiter_if #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
);
    logic [N_SRC-1:0] EX_irq;
    logic             Mask_we;
    logic [N_SRC-1:0] Mask_wdata;
    logic             INT_ack;
    logic             INT_eoi;
    logic             INT_irq;
    logic [31:0]      INT_Vector;
    logic [ID_W-1:0]  INT_id;
    logic [N_SRC-1:0] Pending;
    logic [N_SRC-1:0] Mask;
    logic             In_service;

    modport master (
        output EX_irq, Mask_we, Mask_wdata, INT_ack, INT_eoi,
        input  INT_irq, INT_Vector, INT_id, Pending, Mask, In_service
    );

    modport slave (
        input  EX_irq, Mask_we, Mask_wdata, INT_ack, INT_eoi,
        output INT_irq, INT_Vector, INT_id, Pending, Mask, In_service
    );
endinterface

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: synchronises and edge-detects external lines, latches pending
// events, and sequences one request/acknowledge/end-of-interrupt round at a time without nesting.
module irq_arbiter #(
    parameter int          N_SRC      = 8,
    parameter int          ID_W       = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0020,
    parameter int          VEC_STRIDE = 4
) (
    input  logic         clk,
    input  logic         Rst,
    irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] s1_q, s2_q, s3_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] clr;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  winner;
    logic             winner_vld;
    logic [31:0]      vec_q, vec_d;

    // A fresh rise always wins over an ack clear of the same bit, so no event is lost.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_bit
        assign rise[gi]   = s2_q[gi] & ~s3_q[gi];
        assign pend_d[gi] = rise[gi] | (pend_q[gi] & ~clr[gi]);
    end

    assign elig   = pend_q & ~mask_q;
    assign mask_d = bus.Mask_we ? bus.Mask_wdata : mask_q;

    always_comb begin
        winner     = '0;
        winner_vld = |elig;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (winner_vld) begin
                    id_d    = winner;
                    vec_d   = VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack beats withdrawal when both happen in the same cycle.
                if (bus.INT_ack) begin
                    clr[id_q] = 1'b1;
                    state_d   = SERVICE;
                end else if (!(pend_q[id_q] & ~mask_q[id_q])) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.INT_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            vec_q   <= VEC_BASE;
        end else begin
            state_q <= state_d;
            s1_q    <= bus.EX_irq;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
        end
    end

    assign bus.INT_irq    = (state_q == REQ);
    assign bus.In_service = (state_q == SERVICE);
    assign bus.INT_id     = id_q;
    assign bus.INT_Vector = vec_q;
    assign bus.Pending    = pend_q;
    assign bus.Mask       = mask_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// Randomised and directed bench for irq_arbiter, checked every cycle against a transaction-level
// model built from sample history, a pending set and a three-phase service sequence.
module tb_irq_arbiter;
    localparam int N = 8;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    logic clk;
    logic Rst;

    irq_arbiter_if #(.N_SRC(N), .ID_W(3)) bus ();

    irq_arbiter #(
        .N_SRC(N), .ID_W(3), .VEC_BASE(32'h0000_0020), .VEC_STRIDE(4)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [N-1:0] m_hist[$];
    bit [N-1:0] m_pend;
    bit [N-1:0] m_mask;
    int         m_phase;
    int         m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_hist  = {'0, '0, '0};
        m_pend  = '0;
        m_mask  = '0;
        m_phase = PH_IDLE;
        m_id    = 0;
    endtask

    task automatic model_step(input bit [N-1:0] ex, input bit mwe, input bit [N-1:0] mwd,
                              input bit ack, input bit eoi);
        bit [N-1:0] elig;
        bit [N-1:0] new_pend;
        bit [N-1:0] rise;
        elig     = m_pend & ~m_mask;
        new_pend = m_pend;
        case (m_phase)
            PH_IDLE: if (elig != 0) begin
                m_id    = lowest(elig);
                m_phase = PH_REQ;
            end
            PH_REQ: begin
                if (ack) begin
                    new_pend[m_id] = 1'b0;
                    m_phase        = PH_SVC;
                    $display("txn: source %0d acknowledged, vector %h", m_id, 32'h20 + m_id * 4);
                end else if (!(m_pend[m_id] && !m_mask[m_id])) begin
                    m_phase = PH_IDLE;
                end
            end
            default: if (eoi) m_phase = PH_IDLE;
        endcase
        // An edge seen two samples ago after a low sample three ago becomes pending now.
        rise     = m_hist[1] & ~m_hist[2];
        new_pend = new_pend | rise;
        m_pend   = new_pend;
        if (mwe) m_mask = mwd;
        m_hist.push_front(ex);
        void'(m_hist.pop_back());
    endtask

    task automatic check_all();
        check("irq",    32'(bus.INT_irq),    32'(m_phase == PH_REQ));
        check("insvc",  32'(bus.In_service), 32'(m_phase == PH_SVC));
        check("id",     32'(bus.INT_id),     32'(m_id));
        check("vector", bus.INT_Vector,      32'h20 + 32'(m_id) * 4);
        check("pend",   32'(bus.Pending),    32'(m_pend));
        check("mask",   32'(bus.Mask),       32'(m_mask));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (Rst) model_reset();
        else model_step(bus.EX_irq, bus.Mask_we, bus.Mask_wdata, bus.INT_ack, bus.INT_eoi);
        #1;
        check_all();
    endtask

    task automatic pulse_ack();
        bus.INT_ack = 1'b1;
        cycle();
        bus.INT_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.INT_eoi = 1'b1;
        cycle();
        bus.INT_eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        bus.Mask_we    = 1'b1;
        bus.Mask_wdata = m;
        cycle();
        bus.Mask_we    = 1'b0;
    endtask

    task automatic async_reset();
        Rst = 1'b1;
        #1;
        model_reset();
        check("rst_irq",   32'(bus.INT_irq),    32'd0);
        check("rst_insvc", 32'(bus.In_service), 32'd0);
        check("rst_pend",  32'(bus.Pending),    32'd0);
        check("rst_vec",   bus.INT_Vector,      32'h20);
        cycle();
        Rst = 1'b0;
    endtask

    initial begin
        bit [N-1:0] ex_r;
        Rst            = 1'b1;
        bus.EX_irq     = '0;
        bus.Mask_we    = 1'b0;
        bus.Mask_wdata = '0;
        bus.INT_ack    = 1'b0;
        bus.INT_eoi    = 1'b0;
        model_reset();
        #2;
        check_all();
        cycle();
        cycle();
        Rst = 1'b0;

        // Single source
        bus.EX_irq = 8'h01;
        repeat (3) cycle();
        check("single_pend", 32'(bus.Pending), 32'h01);
        cycle();
        check("single_irq", 32'(bus.INT_irq), 32'd1);
        check("single_vec", bus.INT_Vector, 32'h20);
        pulse_ack();
        check("single_svc", 32'(bus.In_service), 32'd1);
        check("single_clr", 32'(bus.Pending), 32'h00);
        pulse_eoi();
        check("single_idle", 32'(bus.INT_irq), 32'd0);
        bus.EX_irq = '0;
        repeat (4) cycle();

        // Priority between simultaneous rises
        bus.EX_irq = 8'h24;
        repeat (4) cycle();
        check("prio_first_vec", bus.INT_Vector, 32'h28);
        check("prio_first_id", 32'(bus.INT_id), 32'd2);
        pulse_ack();
        pulse_eoi();
        cycle();
        check("prio_second_vec", bus.INT_Vector, 32'h34);
        check("prio_second_id", 32'(bus.INT_id), 32'd5);
        pulse_ack();
        pulse_eoi();
        bus.EX_irq = '0;
        repeat (4) cycle();

        // No preemption while in service
        bus.EX_irq = 8'h40;
        repeat (4) cycle();
        pulse_ack();
        bus.EX_irq = 8'h42;
        repeat (5) cycle();
        check("nopre_irq", 32'(bus.INT_irq), 32'd0);
        check("nopre_svc", 32'(bus.In_service), 32'd1);
        pulse_eoi();
        cycle();
        check("nopre_vec", bus.INT_Vector, 32'h24);
        pulse_ack();
        pulse_eoi();
        bus.EX_irq = '0;
        repeat (4) cycle();

        // Mask withdrawal and re-request
        bus.EX_irq = 8'h08;
        repeat (4) cycle();
        write_mask(8'h08);
        cycle();
        check("wd_irq", 32'(bus.INT_irq), 32'd0);
        check("wd_pend", 32'(bus.Pending), 32'h08);
        write_mask(8'h00);
        cycle();
        check("wd_again_irq", 32'(bus.INT_irq), 32'd1);
        check("wd_again_vec", bus.INT_Vector, 32'h2C);
        pulse_ack();
        pulse_eoi();

        // Level held high yields exactly one round
        bus.EX_irq = 8'h10;
        repeat (4) cycle();
        pulse_ack();
        pulse_eoi();
        repeat (15) cycle();
        check("level_irq", 32'(bus.INT_irq), 32'd0);
        check("level_pend", 32'(bus.Pending), 32'h00);
        bus.EX_irq = '0;
        repeat (4) cycle();

        // Reset while servicing with another event pending
        bus.EX_irq = 8'h01;
        repeat (4) cycle();
        bus.EX_irq = 8'h81;
        pulse_ack();
        repeat (2) cycle();
        check("mid_pend", 32'(bus.Pending), 32'h80);
        check("mid_svc", 32'(bus.In_service), 32'd1);
        bus.EX_irq = '0;
        async_reset();
        repeat (5) cycle();
        check("post_rst_irq", 32'(bus.INT_irq), 32'd0);

        // Randomised traffic
        ex_r = '0;
        for (int k = 0; k < 2500; k++) begin
            ex_r           = ex_r ^ N'($urandom & $urandom & $urandom);
            bus.EX_irq     = ex_r;
            bus.Mask_we    = ($urandom_range(0, 15) == 0);
            bus.Mask_wdata = N'($urandom & $urandom);
            bus.INT_ack    = (m_phase == PH_REQ) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 19) == 0);
            bus.INT_eoi    = (m_phase == PH_SVC) ? ($urandom_range(0, 2) == 0)
                                                 : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Interrupt controller in front of the multi-cycle CPU core.
- Collects up to N_SRC external interrupt lines and latches rising edges as pending events.
- Arbitrates pending events by fixed priority and drives the core's single INT_irq request plus the matching INT_Vector handler address.
- Sequences acknowledge and end-of-interrupt so only one source is in service at a time; no nesting.

Parameters:
N_SRC, 8, number of external interrupt sources (2..16)
ID_W, 3, width of source id; must equal clog2(N_SRC)
VEC_BASE, 32'h00000020, handler address of source 0
VEC_STRIDE, 4, byte distance between consecutive source vectors

Ports:
clk  input  1  system clock, rising edge active
Rst  input  1  asynchronous active-high reset
EX_irq  input  N_SRC  raw external interrupt lines; asynchronous to clk
Mask_we  input  1  load Mask register this cycle
Mask_wdata  input  N_SRC  new mask; bit=1 disables that source
INT_ack  input  1  one-cycle pulse from CPU on entering the IRQ handler
INT_eoi  input  1  one-cycle pulse from CPU on handler return
INT_irq  output  1  interrupt request to CPU
INT_Vector  output  32  handler address of the selected source
INT_id  output  ID_W  selected or in-service source id
Pending  output  N_SRC  latched pending events
Mask  output  N_SRC  current mask register
In_service  output  1  a source is being serviced

Behaviour:
- Reset (async, Rst=1): state=IDLE; Pending, Mask, sync/edge flops=0; INT_id=0; INT_Vector=VEC_BASE; INT_irq=0; In_service=0.
- Sync and edge detection per bit:
  - s1<=EX_irq, s2<=s1, s3<=s2; rise=s2&~s3.
  - Pending bit is set on the edge where rise=1, i.e. the 3rd clk edge after EX_irq goes high.
  - A line held high through reset counts as one rising edge after release.
  - A level held high produces only one event.
- Eligible = Pending & ~Mask. Winner = lowest eligible index (bit 0 highest priority).
- FSM:
  - IDLE: INT_irq=0.
    - If Eligible!=0, latch winner into INT_id at the next edge, INT_Vector=VEC_BASE+INT_id*VEC_STRIDE (32-bit, no overflow check), go to REQ.
  - REQ: INT_irq=1, registered, so high the cycle after entry.
    - INT_id is frozen; a higher-priority arrival does not preempt it.
    - On INT_ack: clear Pending[INT_id], go to SERVICE.
    - If Pending[INT_id]&~Mask[INT_id] becomes 0 (masked) without ack: go to IDLE; INT_irq drops next cycle.
    - Ack has priority over withdrawal in the same cycle.
  - SERVICE: INT_irq=0, In_service=1; INT_id and INT_Vector hold.
    - On INT_eoi: go to IDLE. The next winner can enter REQ at the earliest 1 cycle after return to IDLE.
- Ignored inputs: INT_ack outside REQ, INT_eoi outside SERVICE.
- Same-bit conflict: if a new rise on Pending[INT_id] coincides with the ack clear, the set wins and the bit stays pending.
- Mask_we: Mask<=Mask_wdata at the edge. It takes effect on arbitration the following cycle. It never clears Pending.
- Throughput: at most one handled source per REQ→SERVICE→IDLE round; minimum 3 cycles when ack and eoi arrive immediately.
- Rst asserted mid-REQ or mid-SERVICE: immediate return to reset values; all pending events are lost.

Test Plan:
- Single source: after reset, EX_irq[0] 0→1 → Pending=8'h01 at 3rd edge; INT_irq=1 next cycle, INT_Vector=32'h20, INT_id=0; ack → Pending=0, In_service=1; eoi → IDLE, INT_irq=0.
- Priority: EX_irq[5] and EX_irq[2] rise in the same cycle → INT_id=2, INT_Vector=32'h28; after ack/eoi → INT_id=5, INT_Vector=32'h34.
- No preemption: EX_irq[6] serviced (In_service=1), then EX_irq[1] rises → INT_irq stays 0 until eoi; then INT_id=1, INT_Vector=32'h24.
- Mask withdrawal: source 3 in REQ, write Mask=8'h08 with no ack → INT_irq falls within 2 cycles, Pending=8'h08 retained; write Mask=0 → REQ again with INT_Vector=32'h2C.
- Level/edge: EX_irq[4] held high for 20 cycles → exactly one REQ/ack/eoi round; a 1-cycle EX_irq[4] glitch shorter than the clock is not required to be caught.
- Reset mid-operation: source 0 in SERVICE with Pending=8'h80, assert Rst → same-cycle INT_irq=0, In_service=0, Pending=0, INT_Vector=32'h20; release with EX_irq=0 → stays IDLE.
